// File: rtl/fu_cmd_sequencer.sv
// Command front-end for the shift/rotate functional unit: takes opcode and data
// bytes from the I2C slave, drives the unit, then returns a status/result pair.
//
// state       | meaning
// IDLE        | waiting for an opcode byte
// GET_DATA    | load opcode seen, waiting for the operand byte
// ISSUE       | unit enabled, waiting for data-ready or timeout
// RESP_STATUS | presenting the status byte
// RESP_DATA   | presenting the result byte

module fu_cmd_sequencer #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          fu_en_o,
    output logic [2:0]    fu_sel_o,
    output logic [DW-1:0] fu_din_o,
    output logic          fu_msb_in_o,
    output logic          fu_lsb_in_o,
    input  logic [DW-1:0] fu_dout_i,
    input  logic          fu_data_rdy_i,
    output logic          busy_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_DATA    = 3'd1,
        ISSUE       = 3'd2,
        RESP_STATUS = 3'd3,
        RESP_DATA   = 3'd4
    } state_e;

    localparam logic [7:0]       ST_OK      = 8'h00;
    localparam logic [7:0]       ST_BAD_OP  = 8'h01;
    localparam logic [7:0]       ST_TIMEOUT = 8'h02;
    localparam logic [2:0]       SEL_LOAD   = 3'b001;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             msb_q, msb_d;
    logic             lsb_q, lsb_d;
    logic [DW-1:0]    din_q, din_d;
    logic [7:0]       status_q, status_d;
    logic [DW-1:0]    result_q, result_d;
    logic             rx_ready_q, rx_ready_d;

    logic rx_fire;

    assign rx_fire = rx_valid_i & rx_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        msb_d    = msb_q;
        lsb_d    = lsb_q;
        din_d    = din_q;
        status_d = status_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i[7:5] != 3'b000) begin
                        status_d = ST_BAD_OP;
                        result_d = '0;
                        state_d  = RESP_STATUS;
                    end else begin
                        sel_d   = rx_data_i[2:0];
                        msb_d   = rx_data_i[4];
                        lsb_d   = rx_data_i[3];
                        state_d = (rx_data_i[2:0] == SEL_LOAD) ? GET_DATA : ISSUE;
                    end
                end
            end
            GET_DATA: begin
                if (rx_fire) begin
                    din_d   = rx_data_i[DW-1:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // an unknown ready falls through to the else branch, i.e. counts as 0
                if (fu_data_rdy_i) begin
                    result_d = fu_dout_i;
                    status_d = ST_OK;
                    cnt_d    = '0;
                    state_d  = RESP_STATUS;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    status_d = ST_TIMEOUT;
                    cnt_d    = '0;
                    state_d  = RESP_STATUS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP_STATUS: begin
                if (tx_ready_i) state_d = RESP_DATA;
            end
            RESP_DATA: begin
                if (tx_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // registered so rx_ready only rises on the first clock after reset
        rx_ready_d = (state_d == IDLE) || (state_d == GET_DATA);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            msb_q      <= 1'b0;
            lsb_q      <= 1'b0;
            din_q      <= '0;
            status_q   <= '0;
            result_q   <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            msb_q      <= msb_d;
            lsb_q      <= lsb_d;
            din_q      <= din_d;
            status_q   <= status_d;
            result_q   <= result_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        tx_data_o = '0;
        case (state_q)
            RESP_STATUS: tx_data_o = status_q;
            RESP_DATA:   tx_data_o = 8'(result_q);
            default:     tx_data_o = '0;
        endcase
    end

    assign rx_ready_o  = rx_ready_q;
    assign tx_valid_o  = (state_q == RESP_STATUS) || (state_q == RESP_DATA);
    assign fu_en_o     = (state_q == ISSUE);
    assign fu_sel_o    = sel_q;
    assign fu_din_o    = din_q;
    assign fu_msb_in_o = msb_q;
    assign fu_lsb_in_o = lsb_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fu_cmd_sequencer.sv
// Self-checking bench for fu_cmd_sequencer: directed scenarios plus randomized
// commands against a command-level reference model and a behavioural FU.

module tb_fu_cmd_sequencer;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       fu_en;
    logic [2:0] fu_sel;
    logic [7:0] fu_din;
    logic       fu_msb_in;
    logic       fu_lsb_in;
    logic [7:0] fu_dout = 8'h00;
    logic       fu_data_rdy;
    logic       busy;

    logic       model_rdy = 1'b0;
    logic       stray_rdy;
    int         fu_delay;
    logic [7:0] fu_val;

    int checks = 0;
    int errors = 0;

    // reference model state: what the unit's select/data lines should carry
    logic [2:0] m_sel;
    logic [7:0] m_din;
    logic       m_msb, m_lsb;

    // monitor observations of each enable burst
    int         en_cnt = 0;
    int         en_total = 0;
    int         last_en_len = 0;
    logic       en_unstable = 1'b0;
    logic [2:0] snap_sel = 3'd0;
    logic [7:0] snap_din = 8'd0;
    logic       snap_msb = 1'b0, snap_lsb = 1'b0;

    always #5 clk = ~clk;

    assign fu_data_rdy = model_rdy | stray_rdy;

    fu_cmd_sequencer #(.DW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_ready_o    (rx_ready),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .fu_en_o       (fu_en),
        .fu_sel_o      (fu_sel),
        .fu_din_o      (fu_din),
        .fu_msb_in_o   (fu_msb_in),
        .fu_lsb_in_o   (fu_lsb_in),
        .fu_dout_i     (fu_dout),
        .fu_data_rdy_i (fu_data_rdy),
        .busy_o        (busy)
    );

    // behavioural FU: pulses ready in the fu_delay-th enabled cycle (0 = never)
    always @(negedge clk) begin
        if (reset) begin
            en_cnt    = 0;
            model_rdy = 1'b0;
        end else if (fu_en) begin
            if (en_cnt == 0) begin
                snap_sel    = fu_sel;
                snap_din    = fu_din;
                snap_msb    = fu_msb_in;
                snap_lsb    = fu_lsb_in;
                en_unstable = 1'b0;
            end else if ({fu_sel, fu_din, fu_msb_in, fu_lsb_in} !== {snap_sel, snap_din, snap_msb, snap_lsb}) begin
                en_unstable = 1'b1;
            end
            en_cnt    = en_cnt + 1;
            en_total  = en_total + 1;
            model_rdy = (fu_delay != 0) && (en_cnt == fu_delay);
        end else begin
            if (en_cnt != 0) last_en_len = en_cnt;
            en_cnt    = 0;
            model_rdy = 1'b0;
        end
        fu_dout = fu_val;
    end

    function automatic void ref_cmd(input logic [7:0] op, input logic [7:0] data, input int delay,
                                    input logic [7:0] dout, output logic [7:0] st,
                                    output logic [7:0] res, output int en_len);
        if (op[7:5] != 3'b000) begin
            st = 8'h01; res = 8'h00; en_len = 0;
        end else begin
            m_sel = op[2:0];
            m_msb = op[4];
            m_lsb = op[3];
            if (op[2:0] == 3'b001) m_din = data;
            if (delay >= 1 && delay <= TIMEOUT) begin
                st = 8'h00; res = dout; en_len = delay;
            end else begin
                st = 8'h02; res = 8'h00; en_len = TIMEOUT;
            end
        end
    endfunction

    // called at a negedge; returns at the negedge after the transfer edge
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rx_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        tx_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_valid === 1'b1) begin
                b = tx_data;
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] data, input int delay,
                          input logic [7:0] dout, output logic [7:0] st, output logic [7:0] res,
                          output bit ok);
        bit ok1, ok2, ok3;
        fu_delay = delay;
        fu_val   = dout;
        ok3      = 1'b1;
        res      = 8'h00;
        send_byte(op, ok1);
        if (ok1 && op[7:5] == 3'b000 && op[2:0] == 3'b001) send_byte(data, ok3);
        recv_byte(st, ok2);
        if (ok2) recv_byte(res, ok2);
        ok = ok1 && ok2 && ok3;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        stray_rdy = 1'b0; fu_delay = 0; fu_val = 8'h00;
        m_sel = 3'd0; m_din = 8'h00; m_msb = 1'b0; m_lsb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, tx_valid, tx_data, fu_en, fu_sel, fu_din, fu_msb_in, fu_lsb_in, busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got rx_rdy=%b txv=%b txd=%h en=%b sel=%h din=%h msb=%b lsb=%b busy=%b exp all 0",
                     rx_ready, tx_valid, tx_data, fu_en, fu_sel, fu_din, fu_msb_in, fu_lsb_in, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_at_release got %b exp 0", rx_ready); end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_clock got %b exp 1", rx_ready); end
    endtask

    task automatic test_load();
        logic [7:0] est, eres, st, res;
        int elen, en0;
        bit ok1, ok2, ok3;
        ref_cmd(8'h01, 8'hA5, 4, 8'hA5, est, eres, elen);
        fu_delay = 4; fu_val = 8'hA5; en0 = en_total;
        send_byte(8'h01, ok1);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b1 || fu_en !== 1'b0) begin
            errors++; $display("FAIL load_get_data got rx_rdy=%b busy=%b en=%b exp 1 1 0", rx_ready, busy, fu_en);
        end
        send_byte(8'hA5, ok2);
        recv_byte(st, ok3);
        if (ok3) recv_byte(res, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL load_handshake got timeout exp completion"); end
        checks++;
        if (st !== est || res !== eres) begin errors++; $display("FAIL load_resp got %h %h exp %h %h", st, res, est, eres); end
        checks++;
        if (snap_sel !== 3'b001 || snap_din !== 8'hA5 || en_unstable !== 1'b0) begin
            errors++; $display("FAIL load_fu_lines got sel=%h din=%h unstable=%b exp 1 a5 0", snap_sel, snap_din, en_unstable);
        end
        checks++;
        if (en_total - en0 !== elen || last_en_len !== elen) begin
            errors++; $display("FAIL load_en_len got %0d exp %0d", en_total - en0, elen);
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] est, eres, st, res;
        int elen;
        bit ok1, ok2;
        ref_cmd(8'h12, 8'h00, 3, 8'hD2, est, eres, elen);
        fu_delay = 3; fu_val = 8'hD2;
        send_byte(8'h12, ok1);
        checks++;
        if (rx_ready !== 1'b0 || fu_en !== 1'b1 || fu_msb_in !== 1'b1 || fu_sel !== 3'b010) begin
            errors++; $display("FAIL shr_issue got rx_rdy=%b en=%b msb=%b sel=%h exp 0 1 1 2", rx_ready, fu_en, fu_msb_in, fu_sel);
        end
        recv_byte(st, ok2);
        if (ok2) recv_byte(res, ok2);
        checks++;
        if (!(ok1 && ok2) || st !== est || res !== eres) begin
            errors++; $display("FAIL shr_resp got %h %h ok=%b exp %h %h", st, res, ok1 && ok2, est, eres);
        end
        checks++;
        if (snap_din !== m_din || snap_lsb !== m_lsb || last_en_len !== elen) begin
            errors++; $display("FAIL shr_fields got din=%h lsb=%b len=%0d exp %h %b %0d", snap_din, snap_lsb, last_en_len, m_din, m_lsb, elen);
        end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] est, eres, st, res;
        int elen, en0;
        bit ok;
        en0 = en_total;
        ref_cmd(8'h81, 8'h00, 2, 8'h77, est, eres, elen);
        do_cmd(8'h81, 8'h00, 2, 8'h77, st, res, ok);
        checks++;
        if (!ok || st !== est || res !== eres) begin
            errors++; $display("FAIL bad_resp got %h %h ok=%b exp %h %h", st, res, ok, est, eres);
        end
        checks++;
        if (en_total != en0 || fu_sel !== m_sel) begin
            errors++; $display("FAIL bad_no_issue got en_cycles=%0d sel=%h exp 0 %h", en_total - en0, fu_sel, m_sel);
        end
        ref_cmd(8'h0B, 8'h00, 1, 8'h3C, est, eres, elen);
        do_cmd(8'h0B, 8'h00, 1, 8'h3C, st, res, ok);
        checks++;
        if (!ok || st !== est || res !== eres || snap_lsb !== 1'b1 || snap_sel !== 3'b011) begin
            errors++; $display("FAIL after_bad got %h %h lsb=%b sel=%h exp %h %h 1 3", st, res, snap_lsb, snap_sel, est, eres);
        end
    endtask

    task automatic test_timeout_and_tie();
        logic [7:0] est, eres, st, res;
        int elen;
        bit ok;
        ref_cmd(8'h04, 8'h00, 0, 8'hEE, est, eres, elen);
        do_cmd(8'h04, 8'h00, 0, 8'hEE, st, res, ok);
        checks++;
        if (!ok || st !== est || res !== eres || last_en_len !== elen) begin
            errors++; $display("FAIL timeout got %h %h len=%0d exp %h %h %0d", st, res, last_en_len, est, eres, elen);
        end
        ref_cmd(8'h06, 8'h00, TIMEOUT, 8'h5A, est, eres, elen);
        do_cmd(8'h06, 8'h00, TIMEOUT, 8'h5A, st, res, ok);
        checks++;
        if (!ok || st !== est || res !== eres || last_en_len !== elen) begin
            errors++; $display("FAIL ready_at_timeout got %h %h len=%0d exp %h %h %0d", st, res, last_en_len, est, eres, elen);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] est, eres, st, res, v;
        int elen;
        bit ok1, ok2, seen;
        v = 8'($urandom);
        ref_cmd(8'h05, 8'h00, 2, v, est, eres, elen);
        fu_delay = 2; fu_val = v;
        send_byte(8'h05, ok1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok1 || !seen) begin errors++; $display("FAIL bp_reach_status got no tx_valid exp tx_valid"); end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) fu_val = ~v;
            stray_rdy = (i == 4);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== est || rx_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got txv=%b txd=%h rx_rdy=%b exp 1 %h 0", i, tx_valid, tx_data, rx_ready, est);
            end
            @(negedge clk);
        end
        stray_rdy = 1'b0;
        recv_byte(st, ok2);
        if (ok2) recv_byte(res, ok2);
        checks++;
        if (!ok2 || st !== est || res !== eres) begin
            errors++; $display("FAIL bp_resp got %h %h ok=%b exp %h %h", st, res, ok2, est, eres);
        end
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        int txv_seen;
        fu_delay = 0; fu_val = 8'h99;
        send_byte(8'h13, ok);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_sel = 3'd0; m_din = 8'h00; m_msb = 1'b0; m_lsb = 1'b0;
        checks++;
        if (!ok || {rx_ready, tx_valid, tx_data, fu_en, fu_sel, fu_din, fu_msb_in, fu_lsb_in, busy} !== 24'h0) begin
            errors++; $display("FAIL mid_reset_async got en=%b sel=%h msb=%b lsb=%b busy=%b exp all 0",
                               fu_en, fu_sel, fu_msb_in, fu_lsb_in, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        tx_ready = 1'b1;
        txv_seen = 0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_rx_ready got %b exp 1", rx_ready); end
        for (int i = 0; i < 20; i++) begin
            if (tx_valid !== 1'b0) txv_seen++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        checks++;
        if (txv_seen != 0) begin errors++; $display("FAIL mid_reset_no_tx got %0d tx cycles exp 0", txv_seen); end
    endtask

    task automatic test_random();
        logic [7:0] op, data, dout, est, eres, st, res;
        int delay, elen, en0;
        bit ok;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) op = {3'($urandom_range(1, 7)), 5'($urandom)};
            else                           op = {3'b000, 5'($urandom)};
            if ($urandom_range(0, 3) == 0) op[2:0] = 3'b001;
            data  = 8'($urandom);
            dout  = 8'($urandom);
            delay = $urandom_range(0, 9);
            if (delay == 9) delay = $urandom_range(60, 70);
            en0 = en_total;
            ref_cmd(op, data, delay, dout, est, eres, elen);
            do_cmd(op, data, delay, dout, st, res, ok);
            checks++;
            if (!ok || st !== est || res !== eres || en_total - en0 != elen) begin
                errors++; $display("FAIL rand[%0d] op=%h d=%0d got %h %h len=%0d exp %h %h %0d",
                                   n, op, delay, st, res, en_total - en0, est, eres, elen);
            end
            if (elen != 0) begin
                checks++;
                if (snap_sel !== m_sel || snap_din !== m_din || snap_msb !== m_msb || snap_lsb !== m_lsb || en_unstable !== 1'b0) begin
                    errors++; $display("FAIL rand_fields[%0d] got %h %h %b %b u=%b exp %h %h %b %b",
                                       n, snap_sel, snap_din, snap_msb, snap_lsb, en_unstable, m_sel, m_din, m_msb, m_lsb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_bad_opcode();
        test_timeout_and_tie();
        test_back_pressure();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
